// File: rtl/face_snapshot_bank.sv
// face_snapshot_bank: bank of FACES colour snapshots, CELLS words each.
// Captures a full face from the live colour bus into an auto-selected
// (write-pointer) or explicitly indexed slot, and provides a registered
// random-access read port plus per-slot valid and full status.
//
// Ports:
//   clk, rst       clock (rising edge) and async active-high reset
//   cells_in       live colours, cell i at [i*CW +: CW]
//   cap_req        capture strobe (one capture per cycle while high)
//   cap_sel_en     1: target is cap_face, 0: target is wr_ptr
//   cap_face       explicit target slot
//   clr            synchronous clear of the whole bank
//   rd_face/cell   read address; rd_data returns one cycle later
//   face_valid     bit f set once slot f holds a capture
//   wr_ptr         next auto-capture slot
//   full           all slots valid
//   cap_done/err   one-cycle pulses: capture accepted / refused
module face_snapshot_bank #(
  parameter int unsigned CELLS = 12,
  parameter int unsigned CW    = 12,
  parameter int unsigned FACES = 6,
  parameter int unsigned WRAP  = 0,
  localparam int unsigned FW   = (FACES > 1) ? $clog2(FACES) : 1,
  localparam int unsigned IW   = (CELLS > 1) ? $clog2(CELLS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CELLS*CW-1:0] cells_in,
  input  logic                cap_req,
  input  logic                cap_sel_en,
  input  logic [FW-1:0]       cap_face,
  input  logic                clr,
  input  logic [FW-1:0]       rd_face,
  input  logic [IW-1:0]       rd_cell,
  output logic [CW-1:0]       rd_data,
  output logic [FACES-1:0]    face_valid,
  output logic [FW-1:0]       wr_ptr,
  output logic                full,
  output logic                cap_done,
  output logic                cap_err
);

  // One extra bit so slot/cell range checks work for any FACES/CELLS.
  localparam int unsigned FW1 = FW + 1;
  localparam int unsigned IW1 = IW + 1;

  logic [CW-1:0] mem [FACES][CELLS];

  logic [FW-1:0]    target_c;
  logic             refuse_c;
  logic             accept_c;
  logic             rd_oob_c;
  logic [FACES-1:0] valid_next_c;

  // Capture decision and the face_valid value this edge will produce.
  always_comb begin
    target_c     = cap_sel_en ? cap_face : wr_ptr;
    refuse_c     = 1'b0;
    accept_c     = 1'b0;
    valid_next_c = face_valid;
    if (cap_req && !clr) begin
      if (cap_sel_en) begin
        refuse_c = ({1'b0, cap_face} >= FW1'(FACES));
      end else begin
        refuse_c = full && (WRAP == 0);
      end
      accept_c = !refuse_c;
    end
    if (accept_c) begin
      valid_next_c[target_c] = 1'b1;
    end
    rd_oob_c = ({1'b0, rd_face} >= FW1'(FACES)) ||
               ({1'b0, rd_cell} >= IW1'(CELLS));
  end

  // Snapshot storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned f = 0; f < FACES; f++) begin
        for (int unsigned c = 0; c < CELLS; c++) begin
          mem[f][c] <= '0;
        end
      end
    end else if (clr) begin
      for (int unsigned f = 0; f < FACES; f++) begin
        for (int unsigned c = 0; c < CELLS; c++) begin
          mem[f][c] <= '0;
        end
      end
    end else if (accept_c) begin
      for (int unsigned f = 0; f < FACES; f++) begin
        if (target_c == FW'(f)) begin
          for (int unsigned c = 0; c < CELLS; c++) begin
            mem[f][c] <= cells_in[c*CW +: CW];
          end
        end
      end
    end
  end

  // Status, write pointer and capture pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      face_valid <= '0;
      wr_ptr     <= '0;
      full       <= 1'b0;
      cap_done   <= 1'b0;
      cap_err    <= 1'b0;
    end else if (clr) begin
      face_valid <= '0;
      wr_ptr     <= '0;
      full       <= 1'b0;
      cap_done   <= 1'b0;
      cap_err    <= 1'b0;
    end else begin
      face_valid <= valid_next_c;
      full       <= &valid_next_c;
      cap_done   <= accept_c;
      cap_err    <= refuse_c;
      if (accept_c && !cap_sel_en) begin
        wr_ptr <= (wr_ptr == FW'(FACES - 1)) ? '0 : wr_ptr + FW'(1);
      end
    end
  end

  // Read port; reads the pre-capture contents when a capture hits the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_oob_c) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_face][rd_cell];
    end
  end

endmodule

// File: tb/tb_face_snapshot_bank.sv
// Self-checking bench: two instances (WRAP=0 and WRAP=1) share stimulus and
// are checked every cycle against a slot-array model, plus literal checks.
module tb_face_snapshot_bank;

  localparam int CELLS = 12;
  localparam int CW    = 12;
  localparam int FACES = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [CELLS*CW-1:0] cells_in;
  logic                cap_req, cap_sel_en, clr;
  logic [2:0]          cap_face, rd_face;
  logic [3:0]          rd_cell;

  logic [1:0][11:0] rd_data;
  logic [1:0][5:0]  face_valid;
  logic [1:0][2:0]  wr_ptr;
  logic [1:0]       full, cap_done, cap_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  face_snapshot_bank #(.CELLS(CELLS), .CW(CW), .FACES(FACES), .WRAP(0)) u0 (
    .clk(clk), .rst(rst), .cells_in(cells_in), .cap_req(cap_req),
    .cap_sel_en(cap_sel_en), .cap_face(cap_face), .clr(clr),
    .rd_face(rd_face), .rd_cell(rd_cell), .rd_data(rd_data[0]),
    .face_valid(face_valid[0]), .wr_ptr(wr_ptr[0]), .full(full[0]),
    .cap_done(cap_done[0]), .cap_err(cap_err[0]));

  face_snapshot_bank #(.CELLS(CELLS), .CW(CW), .FACES(FACES), .WRAP(1)) u1 (
    .clk(clk), .rst(rst), .cells_in(cells_in), .cap_req(cap_req),
    .cap_sel_en(cap_sel_en), .cap_face(cap_face), .clr(clr),
    .rd_face(rd_face), .rd_cell(rd_cell), .rd_data(rd_data[1]),
    .face_valid(face_valid[1]), .wr_ptr(wr_ptr[1]), .full(full[1]),
    .cap_done(cap_done[1]), .cap_err(cap_err[1]));

  // Reference model: index 0 refuses auto captures when full, index 1 wraps.
  logic [11:0] m_mem [2][FACES][CELLS];
  logic [5:0]  m_valid [2];
  int          m_ptr [2];
  bit          m_full [2];
  logic [11:0] e_rd [2];
  bit          e_done [2];
  bit          e_err [2];

  always @(posedge clk or posedge rst) begin
    int tgt;
    for (int w = 0; w < 2; w++) begin
      if (rst) begin
        foreach (m_mem[w][f, c]) m_mem[w][f][c] = '0;
        m_valid[w] = '0; m_ptr[w] = 0; m_full[w] = 0;
        e_rd[w] = '0; e_done[w] = 0; e_err[w] = 0;
      end else begin
        e_rd[w] = (int'(rd_face) < FACES && int'(rd_cell) < CELLS) ?
                  m_mem[w][rd_face][rd_cell] : 12'h000;
        e_done[w] = 0;
        e_err[w]  = 0;
        if (clr) begin
          foreach (m_mem[w][f, c]) m_mem[w][f][c] = '0;
          m_valid[w] = '0; m_ptr[w] = 0; m_full[w] = 0;
        end else if (cap_req) begin
          tgt = cap_sel_en ? int'(cap_face) : m_ptr[w];
          if ((cap_sel_en && tgt >= FACES) || (!cap_sel_en && m_full[w] && w == 0)) begin
            e_err[w] = 1;
          end else begin
            for (int c = 0; c < CELLS; c++) m_mem[w][tgt][c] = cells_in[c*CW +: CW];
            m_valid[w][tgt] = 1'b1;
            if (!cap_sel_en) m_ptr[w] = (m_ptr[w] + 1) % FACES;
            e_done[w] = 1;
          end
          m_full[w] = (m_valid[w] == 6'h3f);
        end
      end
    end
  end

  task automatic chk(input string name, input int w, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, w, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int w = 0; w < 2; w++) begin
        chk("rd_data", w, 32'(rd_data[w]), 32'(e_rd[w]));
        chk("face_valid", w, 32'(face_valid[w]), 32'(m_valid[w]));
        chk("wr_ptr", w, 32'(wr_ptr[w]), 32'(m_ptr[w]));
        chk("full", w, 32'(full[w]), 32'(m_full[w]));
        chk("cap_done", w, 32'(cap_done[w]), 32'(e_done[w]));
        chk("cap_err", w, 32'(cap_err[w]), 32'(e_err[w]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_all(input logic [11:0] v);
    for (int c = 0; c < CELLS; c++) cells_in[c*CW +: CW] = v;
  endtask

  task automatic rand_cells();
    for (int c = 0; c < CELLS; c++) cells_in[c*CW +: CW] = 12'($urandom);
  endtask

  initial begin
    rst = 1'b1; cells_in = '0; cap_req = 0; cap_sel_en = 0; clr = 0;
    cap_face = '0; rd_face = '0; rd_cell = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      chk("rst_valid", w, 32'(face_valid[w]), 32'h0);
      chk("rst_ptr", w, 32'(wr_ptr[w]), 32'h0);
      chk("rst_rd", w, 32'(rd_data[w]), 32'h0);
    end

    // Auto pair
    cells_in = '0; cells_in[0 +: 12] = 12'hf00; cells_in[11*12 +: 12] = 12'h0f0;
    cap_req = 1; cyc();
    chk("pair_done0", 0, 32'(cap_done[0]), 32'h1);
    cells_in = '0; cells_in[0 +: 12] = 12'h00f;
    cyc();
    chk("pair_done1", 0, 32'(cap_done[0]), 32'h1);
    cap_req = 0; rd_face = 0; rd_cell = 0; cyc();
    chk("pair_valid", 0, 32'(face_valid[0]), 32'h03);
    chk("pair_ptr", 0, 32'(wr_ptr[0]), 32'h2);
    chk("pair_s0c0", 0, 32'(rd_data[0]), 32'hf00);
    rd_cell = 11; cyc();
    chk("pair_s0c11", 0, 32'(rd_data[0]), 32'h0f0);
    rd_face = 1; rd_cell = 0; cyc();
    chk("pair_s1c0", 0, 32'(rd_data[0]), 32'h00f);

    // Fill remaining four slots, then a seventh auto capture
    cap_req = 1;
    for (int i = 0; i < 4; i++) begin rand_cells(); cyc(); end
    for (int w = 0; w < 2; w++) begin
      chk("fill_full", w, 32'(full[w]), 32'h1);
      chk("fill_ptr", w, 32'(wr_ptr[w]), 32'h0);
    end
    set_all(12'habc); cyc();
    chk("seventh_err0", 0, 32'(cap_err[0]), 32'h1);
    chk("seventh_done0", 0, 32'(cap_done[0]), 32'h0);
    chk("seventh_done1", 1, 32'(cap_done[1]), 32'h1);
    cap_req = 0; rd_face = 0; rd_cell = 0; cyc();
    chk("seventh_s0_0", 0, 32'(rd_data[0]), 32'hf00);
    chk("seventh_s0_1", 1, 32'(rd_data[1]), 32'habc);

    // clr wins over a same-cycle capture
    clr = 1; cap_req = 1; cyc();
    clr = 0; cap_req = 0;
    for (int w = 0; w < 2; w++) begin
      chk("clr_valid", w, 32'(face_valid[w]), 32'h0);
      chk("clr_ptr", w, 32'(wr_ptr[w]), 32'h0);
      chk("clr_full", w, 32'(full[w]), 32'h0);
      chk("clr_pulse", w, 32'({cap_done[w], cap_err[w]}), 32'h0);
    end
    for (int f = 0; f < FACES; f++) begin
      for (int c = 0; c < CELLS; c++) begin
        rd_face = 3'(f); rd_cell = 4'(c); cyc();
        chk("clr_read", 0, 32'(rd_data[0]), 32'h0);
      end
    end

    // Explicit captures, in-range and out-of-range
    set_all(12'hfff); cap_sel_en = 1; cap_face = 3; cap_req = 1; cyc();
    chk("expl_valid", 0, 32'(face_valid[0]), 32'h08);
    chk("expl_ptr", 0, 32'(wr_ptr[0]), 32'h0);
    cap_face = 7; cyc();
    chk("expl_err", 0, 32'(cap_err[0]), 32'h1);
    chk("expl_keep", 0, 32'(face_valid[0]), 32'h08);

    // Read-during-write on slot 2
    set_all(12'hff0); cap_face = 2; cyc();
    set_all(12'hf90); rd_face = 2; rd_cell = 0; cyc();
    chk("rdw_old", 0, 32'(rd_data[0]), 32'hff0);
    cap_req = 0; cyc();
    chk("rdw_new", 0, 32'(rd_data[0]), 32'hf90);
    rd_cell = 12; cyc();
    chk("rd_cell_oob", 0, 32'(rd_data[0]), 32'h0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rand_cells();
      cap_req    = ($urandom_range(0, 99) < 60);
      cap_sel_en = ($urandom_range(0, 99) < 30);
      cap_face   = 3'($urandom_range(0, 7));
      clr        = ($urandom_range(0, 99) < 3);
      rd_face    = 3'($urandom_range(0, 7));
      rd_cell    = 4'($urandom_range(0, 15));
      cyc();
    end

    // Asynchronous reset mid-cycle with a capture in flight
    cap_req = 1; cap_sel_en = 0; clr = 0;
    @(posedge clk); #2 rst = 1'b1; #1;
    for (int w = 0; w < 2; w++) begin
      chk("arst_valid", w, 32'(face_valid[w]), 32'h0);
      chk("arst_ptr", w, 32'(wr_ptr[w]), 32'h0);
      chk("arst_full", w, 32'(full[w]), 32'h0);
      chk("arst_rd", w, 32'(rd_data[w]), 32'h0);
      chk("arst_pulse", w, 32'({cap_done[w], cap_err[w]}), 32'h0);
    end
    cap_req = 0; cyc(); rst = 1'b0;
    for (int f = 0; f < FACES; f++) begin
      rd_face = 3'(f); rd_cell = 4'($urandom_range(0, 11)); cyc();
      chk("arst_read", 1, 32'(rd_data[1]), 32'h0);
    end

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/face_snapshot_bank.md
Name: face_snapshot_bank

Overview:
- Parametrised bank of colour snapshot registers for the cube display path.
- Captures a full face of CELLS colour words from the live colour bus into one of FACES stored slots.
- Slot selection is either automatic, using a write pointer (first capture goes to slot 0, second to slot 1, and so on), or explicit, using a slot index.
- Supplies a registered random-access read port plus valid/full status for the renderer and game FSM.

Parameters:
CELLS, 12, colour cells per face
CW, 12, bits per colour word (RGB444)
FACES, 6, number of stored face slots
WRAP, 0, 1: auto pointer wraps and overwrites when full; 0: auto capture refused when full
Derived (localparam): FW = max(1,$clog2(FACES)), IW = max(1,$clog2(CELLS))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
cells_in  in  CELLS*CW  live colours, cell i at [i*CW +: CW]
cap_req  in  1  capture strobe, sampled each edge (level, one capture per cycle high)
cap_sel_en  in  1  1: target = cap_face; 0: target = wr_ptr (auto)
cap_face  in  FW  explicit target slot
clr  in  1  synchronous clear of bank
rd_face  in  FW  read slot index
rd_cell  in  IW  read cell index
rd_data  out  CW  registered read data
face_valid  out  FACES  bit f set once slot f holds a capture
wr_ptr  out  FW  next auto-capture slot
full  out  1  all face_valid bits set
cap_done  out  1  one-cycle pulse, capture accepted
cap_err  out  1  one-cycle pulse, capture refused

Behaviour:
- Reset (async, rst=1):
  - Storage cleared to 0.
  - face_valid=0, wr_ptr=0, full=0, cap_done=0, cap_err=0, rd_data=0.
- Priority per edge: rst > clr > cap_req.
- clr=1:
  - Storage zeroed; face_valid, wr_ptr and full cleared.
  - cap_req in the same cycle is ignored; no cap_done or cap_err.
- cap_req=1, clr=0:
  - target = cap_sel_en ? cap_face : wr_ptr.
  - Refused if cap_sel_en=1 and cap_face >= FACES.
  - Refused if cap_sel_en=0, full=1 and WRAP=0.
  - On refusal: no storage change, cap_err=1 in the following cycle.
  - Otherwise all CELLS words of cells_in are written into slot target on this edge, and face_valid[target] is set.
  - On acceptance, cap_done=1 in the following cycle (registered pulse); cap_done and cap_err are never high together.
- wr_ptr:
  - Advances only on accepted auto captures: wr_ptr <= (wr_ptr==FACES-1) ? 0 : wr_ptr+1.
  - Explicit captures never move it.
- full: registered; equals &face_valid as of the same edge that updates face_valid (visible the cycle after the last slot is written).
- Read port:
  - rd_data <= storage[rd_face][rd_cell] every edge; 1-cycle latency.
  - rd_face >= FACES or rd_cell >= CELLS returns 0.
  - A read and capture of the same slot on the same edge returns the old (pre-capture) value.
- cap_req held high: one capture per cycle, each handled independently (auto mode advances wr_ptr every cycle).
- Reset mid-operation: all state returns to reset values immediately; a pending cap_done/cap_err pulse is cancelled.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> face_valid=0, wr_ptr=0, full=0, rd_data=0 before next edge; all slots read back 0.
- Auto pair: cells_in cell0=12'hf00, cell11=12'h0f0, cap_req 1 cycle auto; then cell0=12'h00f, cap_req again:
  - Expect cap_done pulse after each capture.
  - Expect face_valid=6'b000011, wr_ptr=2.
  - Expect slot0 cell0=f00, slot0 cell11=0f0, slot1 cell0=00f (rd_data one cycle after address).
- Fill with WRAP=0: six auto captures -> full=1, wr_ptr=0. Seventh -> cap_err=1, cap_done=0, slot0 unchanged. Repeat with WRAP=1 -> seventh accepted, slot0 overwritten with new data.
- Explicit: cap_sel_en=1, cap_face=3 with fff pattern -> face_valid[3]=1, wr_ptr unchanged. cap_face=7 -> cap_err, no change.
- clr with cap_req same cycle -> face_valid=0, wr_ptr=0, full=0, no cap_done/cap_err, all slots read 0.
- Read-during-write: slot2 holds ff0; capture f90 into slot2 while reading slot2 cell0 -> rd_data=ff0, next read returns f90. rd_cell=12 -> rd_data=0.
